vga_scan_gen: RTL

//  Raster timing source for the game display. It generates the pixel enable,
//  the DrawX/DrawY scan coordinates, the sync signals and blanking.
//  It is the producer side of the DrawX/DrawY interface that the colour mapper
//  and the wall, ghost and font lookups consume.
//  It also emits a once-per-frame strobe and a frame counter, which drive game

---
 rtl/vga_timing_pkg.sv | 22 ++
 rtl/mod_counter.sv | 32 +++
 rtl/vga_scan_gen.sv | 131 +++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing definitions for the VGA scan generator.
// The DEF_* values describe the standard 640x480 @ 60 Hz mode driven from a
// 50 MHz system clock; the top level takes them as parameter defaults.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int DEF_CLK_DIV   = 2;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up-counter with a count-enable, a synchronous clear and a wrap
// pulse. The wrap pulse is asserted while the counter sits on its last value
// and is enabled, so it can directly enable the next counter in a chain.
module mod_counter #(
    parameter int WIDTH   = 10,
    parameter int MODULUS = 800
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    // Wrap is a combinational pulse qualified by the enable.
    assign wrap = ce && (count == LAST);

    // Count 0..MODULUS-1, returning to zero after the last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (ce) begin
            count <= wrap ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vga_scan_gen.sv
// Raster timing source: pixel enable, DrawX/DrawY, hs/vs (active low),
// blank_n, a once-per-frame strobe and an 8-bit frame counter.
// Build option: VGA_SYNC_DELAY_EN delays hs, vs and blank_n by one pixel
// period so they line up with a registered RGB stage.
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pixel_ce,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank_n,
    output logic       sync_n,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam coord_t H_VIS_END = coord_t'(H_VISIBLE);
    localparam coord_t HS_START  = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END    = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t V_VIS_END = coord_t'(V_VISIBLE);
    localparam coord_t VS_START  = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END    = coord_t'(V_VISIBLE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;
    coord_t           x_cnt, y_cnt;
    coord_t           x_next, y_next;
    logic             h_wrap, v_wrap;
    logic             hs_r, vs_r, blank_r;
    logic             frame_hit;

    mod_counter #(.WIDTH(DIV_W), .MODULUS(CLK_DIV)) u_div (
        .clk(Clk), .rst(Reset), .ce(1'b1), .clr(1'b0),
        .count(div_cnt), .wrap(div_wrap)
    );

    // The horizontal counter is chained on the divider wrap, which is the
    // same instant as pixel_ce.
    mod_counter #(.WIDTH(10), .MODULUS(H_TOTAL)) u_hcnt (
        .clk(Clk), .rst(Reset), .ce(div_wrap), .clr(1'b0),
        .count(x_cnt), .wrap(h_wrap)
    );

    mod_counter #(.WIDTH(10), .MODULUS(V_TOTAL)) u_vcnt (
        .clk(Clk), .rst(Reset), .ce(h_wrap), .clr(1'b0),
        .count(y_cnt), .wrap(v_wrap)
    );

    assign pixel_ce = (div_cnt == DIV_LAST);
    assign DrawX    = x_cnt;
    assign DrawY    = y_cnt;
    assign sync_n   = 1'b0;

    // Coordinates the counters will hold after the coming pixel edge; only
    // meaningful while pixel_ce is high.
    assign x_next    = h_wrap ? '0 : x_cnt + coord_t'(1);
    assign y_next    = v_wrap ? '0 : (h_wrap ? y_cnt + coord_t'(1) : y_cnt);
    assign frame_hit = pixel_ce && (x_next == '0) && (y_next == V_VIS_END);

    // Decode sync/blank from the next coordinates so they switch on the
    // same edge as DrawX/DrawY.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hs_r    <= 1'b1;
            vs_r    <= 1'b1;
            blank_r <= 1'b1;
        end else if (pixel_ce) begin
            hs_r    <= !((x_next >= HS_START) && (x_next < HS_END));
            vs_r    <= !((y_next >= VS_START) && (y_next < VS_END));
            blank_r <= (x_next < H_VIS_END) && (y_next < V_VIS_END);
        end
    end

    // Frame strobe and counter, both tied to entry into vertical blank.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            frame_start <= frame_hit;
            if (frame_hit) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic hs_d, vs_d, blank_d;

    // One extra pixel of lag on sync and blank to match a registered RGB path.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hs_d    <= 1'b1;
            vs_d    <= 1'b1;
            blank_d <= 1'b1;
        end else if (pixel_ce) begin
            hs_d    <= hs_r;
            vs_d    <= vs_r;
            blank_d <= blank_r;
        end
    end

    assign hs      = hs_d;
    assign vs      = vs_d;
    assign blank_n = blank_d;
`else
    assign hs      = hs_r;
    assign vs      = vs_r;
    assign blank_n = blank_r;
`endif

endmodule
